weight_streamer: RTL and testbench
==================================

# weight_streamer

Reads a configured window of the on-chip weight memory through a single synchronous read port. Emits the window as a valid/ready weight stream toward the compute array. It is the transmit-side counterpart of the stream-to-memory weight loader and uses the same cfg_addr/cfg_length configuration and the same weight_tvalid/tready/tdata stream signals. A 2-entry output buffer absorbs the memory read latency so the block sustains one beat per cycle under back-pressure.

## Interface
- DATA_WIDTH, 32, weight word width.
- MAX_WEIGHTS, 1024, memory depth in words; the local ADDR_WIDTH = $clog2(MAX_WEIGHTS).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  high only in IDLE.
- cfg_addr  in  DATA_WIDTH  start word index.
- cfg_length  in  16  number of words to stream.
- mem_rd_en  out  1  read strobe.
- mem_rd_addr  out  ADDR_WIDTH  read address.
- mem_rd_data  in  DATA_WIDTH  read data, valid exactly one cycle after mem_rd_en.
- weight_tvalid  out  1  stream valid.
- weight_tready  in  1  stream ready.
- weight_tdata  out  DATA_WIDTH  stream data.
- weight_tlast  out  1  last beat of the window; present only with WSTREAM_TLAST_EN.
- busy  out  1  high from accepted cfg until done.
- done  out  1  one-cycle pulse after the final beat.
- weights_sent  out  16  count of completed stream handshakes.
- error  out  1  sticky configuration error.

## Operation
- States: IDLE, STREAM, DONE.
- In IDLE, a configuration is accepted when cfg_valid && cfg_ready. While busy, cfg_valid is ignored.
- A configuration is valid only if cfg_length != 0 and cfg_addr + cfg_length <= MAX_WEIGHTS. The sum is computed at DATA_WIDTH+1 bits, so it cannot wrap.
- Invalid configuration: error is set, the state stays IDLE, and no reads are issued.
- Valid configuration: error and weights_sent clear, the start address and length are latched, and the state moves to STREAM.
- STREAM:
  - Keep rd_remaining, the number of reads not yet issued, and inflight, a 0/1 flag for a read issued last cycle.
  - Keep an output FIFO of depth 2 with count 0..2.
  - Issue a read (mem_rd_en=1, mem_rd_addr = next address, then increment) when rd_remaining > 0 and count + inflight − pop < 2, where pop = weight_tvalid && weight_tready.
  - Data returning from memory is pushed into the FIFO. A push and a pop may occur in the same cycle.
  - weight_tvalid = (count != 0). weight_tdata = FIFO head.
  - Each handshake increments weights_sent.
- When weights_sent reaches the latched length (the final handshake), the state goes to DONE. At that point the FIFO is empty, inflight = 0 and rd_remaining = 0.
- DONE lasts one cycle: done=1, busy=0 next cycle, then the state returns to IDLE. weights_sent holds its final value until the next accepted valid cfg.
- Never read beyond cfg_addr + cfg_length − 1.

## Timing
- Reset values:
  - state = IDLE, cfg_ready = 1.
  - mem_rd_en = 0, mem_rd_addr = 0.
  - weight_tvalid = 0, weight_tdata = 0, weight_tlast = 0.
  - busy = 0, done = 0, weights_sent = 0, error = 0.
  - FIFO emptied.
- Configuration accepted at edge E0:
  - The first mem_rd_en is asserted in the cycle after E0.
  - Data is captured at the next edge.
  - weight_tvalid is first high 2 cycles after E0.
- With weight_tready held high, the block sends one beat per cycle with no bubbles. Length N completes in N+2 cycles after E0, and done pulses in the following cycle.
- Once weight_tvalid is high, weight_tvalid and weight_tdata hold stable until the handshake completes.
- error is registered: it is visible in the cycle after the rejected cfg and is sticky until a valid cfg is accepted.
- Reset asserted mid-stream: all outputs go to their reset values immediately (asynchronous). The window is abandoned and there is no done pulse.
- cfg_ready is a registered output, low in STREAM and DONE.

## Configuration
- WSTREAM_TLAST_EN defined:
  - The weight_tlast port exists.
  - weight_tlast is high together with weight_tvalid exactly on the beat whose handshake makes weights_sent equal the length.
  - weight_tlast is stable under back-pressure like weight_tdata.
- WSTREAM_TLAST_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Memory preloaded with mem[i] = 0x1000+i; cfg_addr=10, cfg_length=4; tready=1 → beats 0x100A..0x100D on consecutive cycles, weights_sent=4, done pulses once, error=0.
- Same window with tready toggled 1,0,0,1,0,1,1 → same 4 beats in order, no duplicates or drops, tdata stable during stalls, no read of address 14.
- cfg_length=0 → error=1, no mem_rd_en, busy=0. Then cfg_addr=0, cfg_length=1 → error clears and one beat 0x1000 is sent.
- cfg_addr=1020, cfg_length=8 (MAX_WEIGHTS=1024) → error=1, no reads. cfg_addr=1020, cfg_length=4 → 4 beats accepted.
- Reset asserted after 2 of 6 beats with cfg_valid pulsed while busy → cfg ignored before reset; after reset all outputs are at reset values; a new cfg_addr=10, cfg_length=3 streams correctly from address 10.
- With WSTREAM_TLAST_EN, cfg_length=1 and cfg_length=5 under random tready → weight_tlast high only on the single/fifth beat.

Source files
------------

// File: rtl/weight_streamer_if.sv
// Handshake bundle for weight_streamer: config request, memory read port, weight stream.
// weight_tlast is present only when WSTREAM_TLAST_EN is defined.
interface weight_streamer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) ();
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [DATA_WIDTH-1:0] cfg_addr;
  logic [15:0]           cfg_length;

  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  logic                  weight_tvalid;
  logic                  weight_tready;
  logic [DATA_WIDTH-1:0] weight_tdata;
`ifdef WSTREAM_TLAST_EN
  logic                  weight_tlast;
`endif

  modport master (
    input  cfg_valid,
    output cfg_ready,
    input  cfg_addr,
    input  cfg_length,
    output mem_rd_en,
    output mem_rd_addr,
    input  mem_rd_data,
    output weight_tvalid,
    input  weight_tready,
`ifdef WSTREAM_TLAST_EN
    output weight_tlast,
`endif
    output weight_tdata
  );

  modport slave (
    output cfg_valid,
    input  cfg_ready,
    output cfg_addr,
    output cfg_length,
    input  mem_rd_en,
    input  mem_rd_addr,
    output mem_rd_data,
    input  weight_tvalid,
    output weight_tready,
`ifdef WSTREAM_TLAST_EN
    input  weight_tlast,
`endif
    input  weight_tdata
  );
endinterface

// File: rtl/weight_streamer.sv
// Streams a window of weight memory out as valid/ready beats via a 2-entry buffer.
// Optional WSTREAM_TLAST_EN adds weight_tlast on the final beat of the window.
module weight_streamer #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_WEIGHTS = 1024
) (
  input  logic                clk,
  input  logic                reset,
  weight_streamer_if.master   bus,
  output logic                busy,
  output logic                done,
  output logic [15:0]         weights_sent,
  output logic                error
);
  localparam int ADDR_WIDTH = $clog2(MAX_WEIGHTS);
  localparam int SW = DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t                state;
  logic                  cfg_ready_q;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [15:0]           rd_remaining;
  logic [15:0]           len_q;
  logic                  inflight;
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] fifo0;
  logic [DATA_WIDTH-1:0] fifo1;

  logic                  pop;
  logic                  issue;
  logic [2:0]            level;
  logic [SW-1:0]         cfg_sum;
  logic                  cfg_ok;
  logic                  last_beat;

  always_comb begin
    pop   = bus.weight_tvalid && bus.weight_tready;
    // occupancy after this cycle's pop, counting the read already in flight
    level = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    issue = (state == STREAM) && (rd_remaining != 16'd0)
            && (level < 3'd2);
    cfg_sum = {1'b0, bus.cfg_addr} + SW'(bus.cfg_length);
    cfg_ok  = (bus.cfg_length != 16'd0)
              && (cfg_sum <= SW'(MAX_WEIGHTS));
    last_beat = pop && (weights_sent == len_q - 16'd1);
  end

  assign bus.cfg_ready     = cfg_ready_q;
  assign bus.mem_rd_en     = issue;
  assign bus.mem_rd_addr   = rd_addr;
  assign bus.weight_tvalid = (count != 2'd0);
  assign bus.weight_tdata  = fifo0;

`ifdef WSTREAM_TLAST_EN
  assign bus.weight_tlast = bus.weight_tvalid
                            && (weights_sent == len_q - 16'd1);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cfg_ready_q  <= 1'b1;
      rd_addr      <= '0;
      rd_remaining <= '0;
      len_q        <= '0;
      inflight     <= 1'b0;
      count        <= 2'd0;
      fifo0        <= '0;
      fifo1        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      weights_sent <= '0;
      error        <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;

      if (issue) begin
        rd_addr      <= rd_addr + 1'b1;
        rd_remaining <= rd_remaining - 16'd1;
      end

      unique case ({inflight, pop})
        2'b10: begin
          if (count == 2'd0) fifo0 <= bus.mem_rd_data;
          else               fifo1 <= bus.mem_rd_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          fifo0 <= fifo1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) fifo0 <= bus.mem_rd_data;
          else begin
            fifo0 <= fifo1;
            fifo1 <= bus.mem_rd_data;
          end
        end
        default: ;
      endcase

      if (pop) weights_sent <= weights_sent + 16'd1;

      unique case (state)
        IDLE: begin
          if (bus.cfg_valid && cfg_ready_q) begin
            if (cfg_ok) begin
              error        <= 1'b0;
              weights_sent <= '0;
              rd_addr      <= bus.cfg_addr[ADDR_WIDTH-1:0];
              rd_remaining <= bus.cfg_length;
              len_q        <= bus.cfg_length;
              busy         <= 1'b1;
              cfg_ready_q  <= 1'b0;
              state        <= STREAM;
            end else begin
              error <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (last_beat) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          cfg_ready_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_weight_streamer.sv
// Directed bench for weight_streamer with a scoreboard of expected beats.
// Define WSTREAM_TLAST_EN to also score weight_tlast.
module tb_weight_streamer;
  localparam int DW = 32;
  localparam int AW = 10;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic        done;
  logic [15:0] weights_sent;
  logic        error;

  logic [31:0] mem [0:1023];
  exp_t        exp_q[$];
  bit          pat_q[$];
  bit          rnd = 1'b0;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int win_lo = 0;
  int win_hi = -1;
  bit prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  weight_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  weight_streamer #(.DATA_WIDTH(DW), .MAX_WEIGHTS(1024)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .weights_sent (weights_sent),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk)
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];

  always @(posedge clk) begin
    #1;
    if (pat_q.size() > 0) bus.weight_tready = pat_q.pop_front();
    else if (rnd) bus.weight_tready = 1'($urandom_range(0, 1));
    else bus.weight_tready = 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.weight_tvalid), 64'd1);
        chk("stall_data", 64'(bus.weight_tdata), 64'(prev_data));
      end
      if (bus.weight_tvalid && bus.weight_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", 64'(bus.weight_tdata), 64'(e.data));
`ifdef WSTREAM_TLAST_EN
          chk("tlast", 64'(bus.weight_tlast), 64'(e.last));
`endif
          beats++;
        end
      end
      prev_stall = bus.weight_tvalid && !bus.weight_tready;
      prev_data  = bus.weight_tdata;
      if (bus.mem_rd_en) begin
        rd_cnt++;
        chk("rd_window",
            64'(int'(bus.mem_rd_addr) >= win_lo
                && int'(bus.mem_rd_addr) <= win_hi), 64'd1);
      end
      if (done) done_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic do_cfg(input int addr, input int len, input bit ok);
    chk("cfg_ready_idle", 64'(bus.cfg_ready), 64'd1);
    if (ok) begin
      for (int i = 0; i < len; i++)
        exp_q.push_back('{mem[addr + i], (i == len - 1)});
      win_lo = addr;
      win_hi = addr + len - 1;
    end
    bus.cfg_addr   = 32'(addr);
    bus.cfg_length = 16'(len);
    bus.cfg_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int len, input int budget, output int cyc);
    int d0;
    bit got;
    d0  = done_cnt;
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("sent_final", 64'(weights_sent), 64'(len));
    chk("busy_at_done", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("done_count", 64'(done_cnt - d0), 64'd1);
    chk("idle_ready", 64'(bus.cfg_ready), 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("sent_hold", 64'(weights_sent), 64'(len));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cfg_ready"}, 64'(bus.cfg_ready), 64'd1);
    chk({tag, "_rd_en"}, 64'(bus.mem_rd_en), 64'd0);
    chk({tag, "_rd_addr"}, 64'(bus.mem_rd_addr), 64'd0);
    chk({tag, "_tvalid"}, 64'(bus.weight_tvalid), 64'd0);
    chk({tag, "_tdata"}, 64'(bus.weight_tdata), 64'd0);
`ifdef WSTREAM_TLAST_EN
    chk({tag, "_tlast"}, 64'(bus.weight_tlast), 64'd0);
`endif
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_sent"}, 64'(weights_sent), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int r0;
    int b0;
    int d0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + 32'(i);
    bus.cfg_valid     = 1'b0;
    bus.cfg_addr      = '0;
    bus.cfg_length    = '0;
    bus.weight_tready = 1'b1;
    bus.mem_rd_data   = '0;

    @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // full-rate window with latency checks
    do_cfg(10, 4, 1'b1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_cfg_ready_low", 64'(bus.cfg_ready), 64'd0);
    chk("t1_first_rd_en", 64'(bus.mem_rd_en), 64'd1);
    chk("t1_first_rd_addr", 64'(bus.mem_rd_addr), 64'd10);
    chk("t1_tvalid_e0", 64'(bus.weight_tvalid), 64'd0);
    @(posedge clk);
    #1;
    chk("t1_tvalid_e1", 64'(bus.weight_tvalid), 64'd0);
    @(posedge clk);
    #1;
    chk("t1_tvalid_e2", 64'(bus.weight_tvalid), 64'd1);
    chk("t1_first_data", 64'(bus.weight_tdata), 64'h100A);
    wait_done(4, 40, cyc);
    chk("t1_latency", 64'(cyc + 2), 64'd6);
    chk("t1_error", 64'(error), 64'd0);

    // back-pressure pattern
    r0 = rd_cnt;
    pat_q = '{1, 0, 0, 1, 0, 1, 1};
    do_cfg(10, 4, 1'b1);
    wait_done(4, 60, cyc);
    chk("t2_reads", 64'(rd_cnt - r0), 64'd4);

    // zero-length rejected, then a single-word window
    r0 = rd_cnt;
    do_cfg(20, 0, 1'b0);
    chk("t3_error", 64'(error), 64'd1);
    chk("t3_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_no_reads", 64'(rd_cnt - r0), 64'd0);
    chk("t3_error_sticky", 64'(error), 64'd1);
    do_cfg(0, 1, 1'b1);
    chk("t3_error_clear", 64'(error), 64'd0);
    wait_done(1, 40, cyc);

    // window past the end rejected, ending exactly at the end accepted
    r0 = rd_cnt;
    do_cfg(1020, 8, 1'b0);
    chk("t4_error", 64'(error), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_no_reads", 64'(rd_cnt - r0), 64'd0);
    do_cfg(1020, 4, 1'b1);
    wait_done(4, 40, cyc);

    // reset mid-stream, cfg pulsed while busy is ignored
    d0 = done_cnt;
    b0 = beats;
    do_cfg(100, 6, 1'b1);
    bus.cfg_addr   = 32'd500;
    bus.cfg_length = 16'd1;
    bus.cfg_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    chk("t5_busy_kept", 64'(busy), 64'd1);
    for (int i = 0; i < 40 && beats < b0 + 2; i++) begin
      @(negedge clk);
    end
    chk("t5_two_beats", 64'(beats - b0), 64'd2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_vals("t5_async");
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
    @(posedge clk);
    #1;
    do_cfg(10, 3, 1'b1);
    chk("t5_restart_addr", 64'(bus.mem_rd_addr), 64'd10);
    wait_done(3, 40, cyc);

    // random back-pressure, final-beat marking
    rnd = 1'b1;
    do_cfg(200, 1, 1'b1);
    wait_done(1, 200, cyc);
    do_cfg(300, 5, 1'b1);
    wait_done(5, 200, cyc);
    rnd = 1'b0;

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
